// File: rtl/cnna_prod_accum_19.sv
// Streaming accumulator that sums cfg_len unsigned 19-bit products and hands the total out on a valid/ready port.
// Build option: define CNNA_ACCUM_SAT_EN to clamp the sum at full scale instead of wrapping.
module cnna_prod_accum_19 #(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  input  logic [18:0]          in_prod,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  logic [1:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [ACC_WIDTH-1:0] r_out_data;

  logic [ACC_WIDTH-1:0] w_acc_add;
  logic                 w_last;
  logic                 w_len_zero;

`ifdef CNNA_ACCUM_SAT_EN
  // One extra bit catches the carry; a clamped acc keeps clamping on every later add.
  logic [ACC_WIDTH:0] w_sum_wide;
  assign w_sum_wide = {1'b0, r_acc} + (ACC_WIDTH+1)'(in_prod);
  assign w_acc_add  = w_sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_wide[ACC_WIDTH-1:0];
`else
  assign w_acc_add = r_acc + ACC_WIDTH'(in_prod);
`endif

  assign w_last     = (r_remaining == LEN_WIDTH'(1));
  assign w_len_zero = (cfg_len == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc <= '0;
            if (w_len_zero) begin
              r_out_data <= '0;
              r_state    <= ST_OUTPUT;
            end else begin
              r_remaining <= cfg_len;
              r_state     <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            r_acc       <= w_acc_add;
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            // Result is captured with the final beat so out_data is ready as OUTPUT begins.
            if (w_last) begin
              r_out_data <= w_acc_add;
              r_state    <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_OUTPUT);
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_cnna_prod_accum_19.sv
// Self-checking bench: directed table, hand-written corner sequences and random ops against a sum model.
module tb_cnna_prod_accum_19;

  localparam int AW = 32;
  localparam int LW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          busy;
  logic [18:0]   in_prod = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  logic          start19 = 1'b0;
  logic [LW-1:0] cfg_len19 = '0;
  logic          busy19;
  logic [18:0]   in_prod19 = '0;
  logic          in_valid19 = 1'b0;
  logic          in_ready19;
  logic [18:0]   out_data19;
  logic          out_valid19;
  logic          out_ready19 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  cnna_prod_accum_19 #(.ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_prod(in_prod), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  cnna_prod_accum_19 #(.ACC_WIDTH(19), .LEN_WIDTH(LW)) u_dut19 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start19), .cfg_len(cfg_len19), .busy(busy19),
    .in_prod(in_prod19), .in_valid(in_valid19), .in_ready(in_ready19),
    .out_data(out_data19), .out_valid(out_valid19), .out_ready(out_ready19)
  );

  typedef struct {
    int          len;
    int unsigned prod[4];
    int          dly;
    logic [63:0] exp_v;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Sum of non-negative terms: saturation reduces to min(total, full scale).
  function automatic logic [63:0] model(input int width, input longint total);
    logic [63:0] mx;
    mx = (64'd1 << width) - 64'd1;
`ifdef CNNA_ACCUM_SAT_EN
    return (total > mx) ? mx : total;
`else
    return total & mx;
`endif
  endfunction

  task automatic run_op(input int len, input int unsigned prods[$], input int max_gap,
                        input int ready_delay, input logic [63:0] exp_v);
    int gap;
    start   = 1'b1;
    cfg_len = len[LW-1:0];
    tick();
    start   = 1'b0;
    cfg_len = LW'($urandom);
    check("busy_after_start", busy, 1);
    if (len == 0) check("zero_len_in_ready", in_ready, 0);
    for (int i = 0; i < len; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_prod  = 19'($urandom);
        tick();
        check("stall_in_ready", in_ready, 1);
        check("stall_out_valid", out_valid, 0);
      end
      check("in_ready", in_ready, 1);
      in_prod  = prods[i][18:0];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (i < len - 1) check("early_out_valid", out_valid, 0);
    end
    check("out_valid_latency", out_valid, 1);
    check("out_data", out_data, exp_v);
    check("out_in_ready", in_ready, 0);
    repeat (ready_delay) begin
      in_valid = 1'b1;
      in_prod  = 19'($urandom);
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, exp_v);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
    check("done_hold_data", out_data, exp_v);
  endtask

  task automatic run19(input int unsigned prods[$], input logic [63:0] exp_v);
    start19   = 1'b1;
    cfg_len19 = LW'(prods.size());
    tick();
    start19 = 1'b0;
    foreach (prods[i]) begin
      check("w19_in_ready", in_ready19, 1);
      in_prod19  = prods[i][18:0];
      in_valid19 = 1'b1;
      tick();
      in_valid19 = 1'b0;
    end
    check("w19_out_valid", out_valid19, 1);
    check("w19_out_data", out_data19, exp_v);
    out_ready19 = 1'b1;
    tick();
    out_ready19 = 1'b0;
    check("w19_done_busy", busy19, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned q[$];
    longint total;
    int len;

    vecs[0] = '{len:3, prod:'{100, 200, 300, 0},             dly:0, exp_v:64'd600};
    vecs[1] = '{len:0, prod:'{0, 0, 0, 0},                   dly:0, exp_v:64'd0};
    vecs[2] = '{len:1, prod:'{9, 0, 0, 0},                   dly:1, exp_v:64'd9};
    vecs[3] = '{len:2, prod:'{5, 7, 0, 0},                   dly:4, exp_v:64'd12};
    vecs[4] = '{len:4, prod:'{524287, 524287, 524287, 524287}, dly:0, exp_v:64'd2097148};
    vecs[5] = '{len:4, prod:'{0, 0, 0, 0},                   dly:2, exp_v:64'd0};
    vecs[6] = '{len:2, prod:'{1, 524286, 0, 0},              dly:0, exp_v:64'd524287};

    // Reset is applied before any clock edge, so outputs must clear asynchronously.
    #1 ap_rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst19_out_data", out_data19, 0);
    tick();
    tick();
    #2 ap_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      q = {};
      for (int j = 0; j < vecs[v].len; j++) q.push_back(vecs[v].prod[j]);
      run_op(vecs[v].len, q, 0, vecs[v].dly, vecs[v].exp_v);
      $display("vec %0d len=%0d expected=%0d", v, vecs[v].len, vecs[v].exp_v);
    end

    // start mid-ACCUM is ignored; start on the OUTPUT handshake cycle is ignored too
    start = 1'b1; cfg_len = 16'd2;
    tick();
    start = 1'b0;
    in_prod = 19'd11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b1; cfg_len = 16'd7;
    tick();
    start = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_out_valid", out_valid, 0);
    in_prod = 19'd22; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ign_out_valid2", out_valid, 1);
    check("ign_out_data", out_data, 33);
    out_ready = 1'b1; start = 1'b1; cfg_len = 16'd3;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("no_bypass_busy", busy, 0);
    $display("seq ignored-start result=%0d", out_data);

    // Reset mid-ACCUM abandons the sum and clears out_data without an edge
    start = 1'b1; cfg_len = 16'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_prod = 19'd50;
    tick();
    in_prod = 19'd60;
    tick();
    in_valid = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    in_valid = 1'b1;
    tick();
    check("in_rst_out_valid", out_valid, 0);
    #2 ap_rst = 1'b0;
    in_valid = 1'b0;
    start = 1'b1; cfg_len = 16'd1;
    tick();
    start = 1'b0;
    check("post_rst_busy", busy, 1);
    check("post_rst_out_valid", out_valid, 0);
    in_prod = 19'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_idle", busy, 0);
    $display("seq reset-mid-op result=%0d", out_data);

    // Narrow accumulator: overflow behaviour depends on the build option
    q = {524287, 2};
    run19(q, model(19, 64'd524289));
    $display("w19 op 524287+2 expected=%0d", model(19, 64'd524289));
    q = {524287, 2, 0, 5};
    run19(q, model(19, 64'd524294));
    $display("w19 op 524287+2+0+5 expected=%0d", model(19, 64'd524294));
    q = {100, 200};
    run19(q, model(19, 64'd300));
    $display("w19 op 100+200 expected=%0d", model(19, 64'd300));

    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, 6);
      q = {};
      total = 0;
      for (int j = 0; j < len; j++) begin
        q.push_back($urandom_range(0, 524287));
        total += longint'(q[j]);
      end
      run_op(len, q, 2, $urandom_range(0, 3), model(AW, total));
      $display("rand %0d len=%0d expected=%0d", r, len, model(AW, total));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnna_prod_accum_19.md
CNNA_PROD_ACCUM_19 -- requirements
Module: cnna_prod_accum_19

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: accumulator and result width; legal range 19..48.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the term-count field.
REQ-003 SHALL have port ap_clk, input, 1: sole clock; all state is rising-edge triggered.
REQ-004 SHALL have port ap_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a dot-product of cfg_len terms.
REQ-006 SHALL have port cfg_len, input, LEN_WIDTH: term count, sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1: high outside IDLE.
REQ-008 SHALL have port in_prod, input, 19: unsigned product from the 10x9 multiplier stage.
REQ-009 SHALL have port in_valid, input, 1: in_prod is valid.
REQ-010 SHALL have port in_ready, output, 1: the block accepts in_prod.
REQ-011 SHALL have port out_data, output, ACC_WIDTH: accumulated sum.
REQ-012 SHALL have port out_valid, output, 1: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1: the consumer accepts out_data.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCUM and OUTPUT.
REQ-015 IDLE: start=1 with cfg_len>0 SHALL latch remaining=cfg_len, clear acc to 0 and move to ACCUM next cycle.
REQ-016 IDLE: start=1 with cfg_len=0 SHALL clear acc to 0 and move directly to OUTPUT, consuming no input.
REQ-017 in_ready SHALL equal 1 only in ACCUM; a beat transfers when in_valid and in_ready are both 1.
REQ-018 Each transfer SHALL do acc <= acc + zero-extended in_prod and remaining <= remaining - 1.
REQ-019 The transfer with remaining=1 SHALL move the FSM to OUTPUT, so out_valid rises the cycle after the last accepted beat (latency 1).
REQ-020 ACCUM with in_valid=0 SHALL hold all state; no timeout.
REQ-021 OUTPUT: out_valid=1 and out_data=acc, both held stable until out_ready=1; the handshake cycle SHALL return the FSM to IDLE.
REQ-022 out_valid SHALL be 0 and out_data SHALL hold its last value outside OUTPUT.
REQ-023 start while busy=1 SHALL be ignored, with no effect on state or on the sampled cfg_len.
REQ-024 A start accepted in IDLE SHALL take effect in the same cycle that OUTPUT returns to IDLE only on the following cycle; there is no back-to-back start bypass.
REQ-025 cfg_len = 2^LEN_WIDTH-1 SHALL be supported with no counter wrap.

Reset
REQ-026 ap_rst=1 SHALL immediately force FSM=IDLE, acc=0, remaining=0, out_data=0, out_valid=0, in_ready=0 and busy=0, independent of ap_clk.
REQ-027 Reset asserted mid-ACCUM or mid-OUTPUT SHALL abandon the operation with no partial result emitted.
REQ-028 After ap_rst deasserts, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-029 Macro CNNA_ACCUM_SAT_EN defined: any add whose true sum exceeds 2^ACC_WIDTH-1 SHALL clamp acc to 2^ACC_WIDTH-1, and acc SHALL stay there for the rest of the operation.
REQ-030 Macro CNNA_ACCUM_SAT_EN undefined: the add SHALL wrap modulo 2^ACC_WIDTH, with no saturation logic present.

Verification
REQ-031 Basic sum, defaults: start, cfg_len=3, prods 100, 200, 300 with in_valid always 1 -> out_valid one cycle after the third beat, out_data=600, busy=0 after the out_ready handshake.
REQ-032 Zero length: start, cfg_len=0 -> OUTPUT on the next cycle, out_data=0, in_ready never 1.
REQ-033 Backpressure: cfg_len=2, prods 5 and 7, out_ready=0 for 4 cycles -> out_data=12 held stable with out_valid=1 throughout, then IDLE after out_ready=1.
REQ-034 Overflow, ACC_WIDTH=19: cfg_len=2, prods 524287 and 2 -> out_data=524287 with CNNA_ACCUM_SAT_EN defined, out_data=1 without it.
REQ-035 Reset mid-op: cfg_len=4, 2 beats accepted, pulse ap_rst -> outputs zero asynchronously and out_valid never rises; a new start with cfg_len=1, prod 9 -> out_data=9.
REQ-036 Ignored start: during ACCUM with cfg_len=2, pulse start with cfg_len=7 -> result is completed after exactly 2 beats.
